ninjakun_busarb: RTL



---
 rtl/ninjakun_busarb_if.sv | 50 +++++
 rtl/ninjakun_busarb.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ninjakun_busarb_if.sv
// ninjakun_busarb_if: CPU request/stall lines and the shared video bus,
// grouped for the arbiter and the blocks around it.
interface ninjakun_busarb_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic [1:0]    HWTYPE;
  logic [AW-1:0] CP0_ADR;
  logic [AW-1:0] CP1_ADR;
  logic          CP0_REQ;
  logic          CP1_REQ;
  logic          CP0_WR;
  logic          CP1_WR;
  logic [DW-1:0] CP0_DO;
  logic [DW-1:0] CP1_DO;
  logic          CP0_WAIT;
  logic          CP1_WAIT;
  logic [6:0]    BUS_CS;
  logic [AW-1:0] BUS_ADR;
  logic          BUS_WR;
  logic [DW-1:0] BUS_DO;
  logic          BUS_GNT;
  logic [DW-1:0] SCRX;
  logic [DW-1:0] SCRY;
  logic          ERR;

  modport master (
    output HWTYPE,
    output CP0_ADR, CP1_ADR,
    output CP0_REQ, CP1_REQ,
    output CP0_WR, CP1_WR,
    output CP0_DO, CP1_DO,
    input  CP0_WAIT, CP1_WAIT,
    input  BUS_CS, BUS_ADR, BUS_WR,
    input  BUS_DO, BUS_GNT,
    input  SCRX, SCRY, ERR
  );

  modport slave (
    input  HWTYPE,
    input  CP0_ADR, CP1_ADR,
    input  CP0_REQ, CP1_REQ,
    input  CP0_WR, CP1_WR,
    input  CP0_DO, CP1_DO,
    output CP0_WAIT, CP1_WAIT,
    output BUS_CS, BUS_ADR, BUS_WR,
    output BUS_DO, BUS_GNT,
    output SCRX, SCRY, ERR
  );
endinterface

// File: rtl/ninjakun_busarb.sv
// ninjakun_busarb: two-CPU address decoder and round-robin video bus
// arbiter with grant timeout and Raiders5 scroll registers.
module ninjakun_busarb #(
  parameter int AW  = 16,
  parameter int DW  = 8,
  parameter int TMO = 255
) (
  input  logic             CLK,
  input  logic             RESET_N,
  ninjakun_busarb_if.slave b
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_G0   = 2'd1;
  localparam logic [1:0] S_G1   = 2'd2;
  localparam logic [7:0] TMOV   = TMO[7:0];

  // Target bits: {SCRY,SCRX,PAL,SPA,BGV,FGV,PSG}
  function automatic logic [6:0] dec(
    input logic       cpu,
    input logic [1:0] hw,
    input logic [15:0] a
  );
    logic [6:0] t;
    t = '0;
    unique case (hw)
      2'd0: begin
        t[0] = a[15:2] == 14'h2000;
        t[1] = a[15:11] == 5'b11000;
        t[2] = a[15:11] == 5'b11001;
        t[3] = a[15:11] == 5'b11010;
        t[4] = a[15:11] == 5'b11011;
      end
      2'd1: if (!cpu) begin
        t[0] = a[15:2] == 14'h3000;
        t[1] = a[15:11] == 5'b10100;
        t[2] = a[15:11] == 5'b10101;
        t[3] = a[15:11] == 5'b10110;
      end
      2'd2: if (!cpu) begin
        t[0] = a[15:2] == 14'h2800;
        t[3] = a[15:11] == 5'b10000;
        t[2] = a[15:11] == 5'b10001;
      end
      2'd3: if (!cpu) begin
        t[5] = a == 16'hA000;
        t[6] = a == 16'hA001;
        t[0] = a[15:2] == 14'h3000;
        t[3] = a[15:11] == 5'b10000;
        t[1] = a[15:11] == 5'b10001;
        t[2] = a[15:11] == 5'b10010;
        t[4] = a[15:11] == 5'b11010;
      end else begin
        t[5] = a == 16'hE000;
        t[6] = a == 16'hE001;
        t[0] = a[15:2] == 14'h2000;
      end
    endcase
    return t;
  endfunction

  logic [1:0]    st_q, st_d;
  logic [6:0]    cs_q, cs_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] do_q, do_d;
  logic          gnt_q, gnt_d;
  logic          prio_q, prio_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [1:0]    blk_q, blk_d;
  logic          err_q, err_d;
  logic [DW-1:0] scrx_q, scrx_d;
  logic [DW-1:0] scry_q, scry_d;

  logic [6:0] cs0, cs1;
  logic [1:0] req, hit, pend;
  logic       tmo, take, win, own, rel;

  assign cs0  = dec(1'b0, b.HWTYPE, b.CP0_ADR[15:0]);
  assign cs1  = dec(1'b1, b.HWTYPE, b.CP1_ADR[15:0]);
  assign req  = {b.CP1_REQ, b.CP0_REQ};
  assign hit  = {|cs1, |cs0};
  assign pend = req & hit & ~blk_q;
  assign own  = st_q == S_G1;
  assign tmo  = (TMOV != 8'd0) && (cnt_q >= TMOV - 8'd1);

  always_comb begin
    st_d   = st_q;
    cs_d   = cs_q;
    adr_d  = adr_q;
    wr_d   = wr_q;
    do_d   = do_q;
    gnt_d  = gnt_q;
    prio_d = prio_q;
    err_d  = err_q;
    scrx_d = scrx_q;
    scry_d = scry_q;
    cnt_d  = (cnt_q == TMOV) ? cnt_q : cnt_q + 8'd1;
    blk_d  = blk_q & req;
    take   = 1'b0;
    win    = 1'b0;
    rel    = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        cnt_d = cnt_q;
        if (pend[0] && (!pend[1] || prio_q)) begin
          take = 1'b1;
        end else if (pend[1]) begin
          take = 1'b1;
          win  = 1'b1;
        end
      end
      S_G0, S_G1: begin
        if (!req[own]) begin
          rel = 1'b1;
        end else if (tmo) begin
          rel        = 1'b1;
          err_d      = 1'b1;
          blk_d[own] = 1'b1;
        end
        if (rel) begin
          st_d = S_IDLE;
          cs_d = '0;
          if (pend[~own]) begin
            take = 1'b1;
            win  = ~own;
          end
        end
      end
      default: begin
        st_d = S_IDLE;
        cs_d = '0;
      end
    endcase
    if (take) begin
      st_d   = win ? S_G1 : S_G0;
      cs_d   = win ? cs1 : cs0;
      adr_d  = win ? b.CP1_ADR : b.CP0_ADR;
      wr_d   = win ? b.CP1_WR : b.CP0_WR;
      do_d   = win ? b.CP1_DO : b.CP0_DO;
      gnt_d  = win;
      prio_d = win;
      cnt_d  = '0;
      if (wr_d && cs_d[5]) scrx_d = do_d;
      if (wr_d && cs_d[6]) scry_d = do_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      st_q   <= S_IDLE;
      cs_q   <= '0;
      adr_q  <= '0;
      wr_q   <= 1'b0;
      do_q   <= '0;
      gnt_q  <= 1'b0;
      prio_q <= 1'b1;
      cnt_q  <= '0;
      blk_q  <= '0;
      err_q  <= 1'b0;
      scrx_q <= '0;
      scry_q <= '0;
    end else begin
      st_q   <= st_d;
      cs_q   <= cs_d;
      adr_q  <= adr_d;
      wr_q   <= wr_d;
      do_q   <= do_d;
      gnt_q  <= gnt_d;
      prio_q <= prio_d;
      cnt_q  <= cnt_d;
      blk_q  <= blk_d;
      err_q  <= err_d;
      scrx_q <= scrx_d;
      scry_q <= scry_d;
    end
  end

  assign b.CP0_WAIT = req[0] & hit[0] & (st_q != S_G0);
  assign b.CP1_WAIT = req[1] & hit[1] & (st_q != S_G1);
  assign b.BUS_CS   = cs_q;
  assign b.BUS_ADR  = adr_q;
  assign b.BUS_WR   = wr_q;
  assign b.BUS_DO   = do_q;
  assign b.BUS_GNT  = gnt_q;
  assign b.SCRX     = scrx_q;
  assign b.SCRY     = scry_q;
  assign b.ERR      = err_q;

endmodule
